// File: rtl/riscv_bus_slave_mem.sv
// riscv_bus_slave_mem
// ---------------------------------------------------------------------------
// Responder end of the core's req/gnt/rvalid memory bus. It holds a
// word-organised RAM with byte-enable writes, a fixed number of wait states
// and at most one outstanding transaction.
//
// Handshake: a request is accepted on a rising edge where req && gnt. gnt is
// high exactly while the FSM is IDLE and does not look at req. Exactly one
// rvalid pulse (one cycle) answers every accepted request, WAIT_CYCLES+1
// cycles after the acceptance cycle. The master keeps req/we/be/addr/wdata
// stable until it sees gnt.
//
// Parameters:
//   ADDR_WIDTH  - byte address width (addr[1:0] ignored)
//   DEPTH_WORDS - number of 32-bit words, power of two, >= 2
//   WAIT_CYCLES - extra cycles between grant and response, 0..15
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous reset, ACTIVE-HIGH despite the name
//   req       - request valid          gnt    - request accepted (IDLE)
//   we        - 1 write / 0 read       be     - write byte enables
//   addr      - byte address           wdata  - write data
//   rvalid    - one-cycle response     rdata  - read data (0 for writes)
//   err       - out-of-range response (only with RISCV_BUS_SLAVE_ERR_EN)
//   dbg_state - current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Optional feature macro: RISCV_BUS_SLAVE_ERR_EN. When defined, addresses
// with any bit set above the word index are flagged with err, writes to them
// are dropped and reads return zero. When undefined, such addresses wrap.
// ---------------------------------------------------------------------------
module riscv_bus_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  output logic                  gnt,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  rvalid,
`ifdef RISCV_BUS_SLAVE_ERR_EN
  output logic                  err,
`endif
  output logic [31:0]           rdata,
  output logic [1:0]            dbg_state
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;

  // Request captured at acceptance; used when the access happens later.
  logic                  we_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [31:0]           mem_q [DEPTH_WORDS];

  // Access selected for the edge that enters RESP.
  logic                  acc_fire;
  logic                  acc_we;
  logic [3:0]            acc_be;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [IDX_W-1:0]      acc_idx;
  logic                  acc_oor;
  logic                  unused_acc;

  assign gnt       = (state_q == S_IDLE);
  assign dbg_state = state_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_INIT;
          state_d = ZERO_WAIT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RESP is always left after one cycle, so state_d==RESP marks entry only.
  assign acc_fire = (state_d == S_RESP);

  // With no wait states the access happens in the acceptance cycle itself,
  // before the latched copy exists, so the live bus is used.
  always_comb begin
    if (ZERO_WAIT) begin
      acc_we    = we;
      acc_be    = be;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_we    = we_q;
      acc_be    = be_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx    = acc_addr[IDX_W+1:2];
  // Byte-offset bits (and, without the error feature, high bits) are unused.
  assign unused_acc = ^acc_addr;

`ifdef RISCV_BUS_SLAVE_ERR_EN
  assign acc_oor = ((acc_addr >> (IDX_W + 2)) != '0);
`else
  assign acc_oor = 1'b0;
`endif

  // Control, request latch and registered response.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
`ifdef RISCV_BUS_SLAVE_ERR_EN
      err     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req) begin
        we_q    <= we;
        be_q    <= be;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      rvalid <= acc_fire;
      // rdata holds between responses.
      if (acc_fire) begin
        if (acc_we || acc_oor) rdata <= 32'd0;
        else                   rdata <= mem_q[acc_idx];
      end
`ifdef RISCV_BUS_SLAVE_ERR_EN
      err <= acc_fire && acc_oor;
`endif
    end
  end

  // RAM: never cleared; a write in flight is dropped if reset hits its edge.
  always_ff @(posedge clk) begin
    if (!rst_n && acc_fire && acc_we && !acc_oor) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_be[k]) mem_q[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_bus_slave_mem.sv
module tb_riscv_bus_slave_mem;

  localparam int WAIT2 = 2;

  logic        clk;
  logic        rst_n;

  // Instance with two wait states.
  logic        req, we, gnt, rvalid;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  dbg_state;
`ifdef RISCV_BUS_SLAVE_ERR_EN
  logic        err;
`endif

  // Instance with zero wait states.
  logic        req0, we0, gnt0, rvalid0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [1:0]  dbg_state0;
`ifdef RISCV_BUS_SLAVE_ERR_EN
  logic        err0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  riscv_bus_slave_mem #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .rvalid(rvalid),
`ifdef RISCV_BUS_SLAVE_ERR_EN
    .err(err),
`endif
    .rdata(rdata), .dbg_state(dbg_state)
  );

  riscv_bus_slave_mem #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .we(we0), .be(be0),
    .addr(addr0), .wdata(wdata0), .rvalid(rvalid0),
`ifdef RISCV_BUS_SLAVE_ERR_EN
    .err(err0),
`endif
    .rdata(rdata0), .dbg_state(dbg_state0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one transaction on the 2-wait instance ----------------
  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic txn2(input string tag, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int k;
    logic gnt_low;
    logic [31:0] e;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    exp_q.push_back(exp_rd);
    n = 0;
    while (!gnt && n < 20) begin @(negedge clk); n++; end
    check({tag, "_gnt"}, {31'd0, gnt}, 32'd1);
    @(posedge clk);           // acceptance edge
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0;
    k = 1;
    gnt_low = 1'b1;
    while (!rvalid && k < 20) begin
      if (gnt) gnt_low = 1'b0;
      @(negedge clk);
      k++;
    end
    if (gnt) gnt_low = 1'b0;
    check({tag, "_lat"}, k, WAIT2 + 1);
    check({tag, "_gnt_low"}, {31'd0, gnt_low}, 32'd1);
    e = exp_q.pop_front();
    check({tag, "_rdata"}, rdata, e);
`ifdef RISCV_BUS_SLAVE_ERR_EN
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
`else
    if (exp_err) check({tag, "_err_unexpected"}, 32'd1, 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } op_t;

  op_t ops0[6];

  initial begin
    rst_n = 1'b1;
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h01020304;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'd0; addr0 = 32'd0; wdata0 = 32'd0;

    // 1. Reset held two cycles with a pending request.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_gnt", {31'd0, gnt}, 32'd1);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    end
    rst_n = 1'b0;
    txn2("first_wr", 1'b1, 4'hF, 32'h40, 32'h01020304, 32'd0, 1'b0);
    @(negedge clk);
    txn2("first_rd", 1'b0, 4'h0, 32'h40, 32'd0, 32'h01020304, 1'b0);

    // 2. Full write then read.
    @(negedge clk);
    txn2("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    txn2("rd10", 1'b0, 4'h0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // 3. Byte-enable merge: lanes 0 and 2 from the new data.
    txn2("wr10_be", 1'b1, 4'b0101, 32'h10, 32'h11223344, 32'd0, 1'b0);
    txn2("rd10_be", 1'b0, 4'h0, 32'h10, 32'd0, 32'hDE22BE44, 1'b0);
    // be=0 write changes nothing but still answers.
    txn2("wr10_be0", 1'b1, 4'b0000, 32'h10, 32'h99999999, 32'd0, 1'b0);
    txn2("rd10_be0", 1'b0, 4'h0, 32'h10, 32'd0, 32'hDE22BE44, 1'b0);

    // 4. Zero wait states, req held high back to back.
    ops0[0] = '{1'b1, 32'h0, 32'h11111111, 32'd0};
    ops0[1] = '{1'b1, 32'h4, 32'h22222222, 32'd0};
    ops0[2] = '{1'b1, 32'h8, 32'h33333333, 32'd0};
    ops0[3] = '{1'b0, 32'h0, 32'h0, 32'h11111111};
    ops0[4] = '{1'b0, 32'h4, 32'h0, 32'h22222222};
    ops0[5] = '{1'b0, 32'h8, 32'h0, 32'h33333333};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      req0 = 1'b1; we0 = ops0[i].w; be0 = 4'hF; addr0 = ops0[i].a; wdata0 = ops0[i].d;
      exp_q.push_back(ops0[i].exp);
      check("z_gnt", {31'd0, gnt0}, 32'd1);
      check("z_rvalid_idle", {31'd0, rvalid0}, 32'd0);
      @(negedge clk);
      check("z_rvalid", {31'd0, rvalid0}, 32'd1);
      check("z_gnt_resp", {31'd0, gnt0}, 32'd0);
      check("z_rdata", rdata0, exp_q.pop_front());
      @(negedge clk);
    end
    req0 = 1'b0;

    // 5. Reset during WAIT drops the write.
    txn2("wr20", 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h12345678;
    check("rw_gnt", {31'd0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0;
    check("rw_in_wait", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check("rw_state", {30'd0, dbg_state}, 32'd0);
    check("rw_gnt_after", {31'd0, gnt}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rw_no_rvalid", {31'd0, rvalid}, 32'd0);
      @(negedge clk);
    end
    txn2("rd20", 1'b0, 4'h0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);

    // 6. Address above the RAM size.
    txn2("wr0", 1'b1, 4'hF, 32'h0, 32'h0BADF00D, 32'd0, 1'b0);
`ifdef RISCV_BUS_SLAVE_ERR_EN
    txn2("wr1000", 1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, 32'd0, 1'b1);
    txn2("rd0_oor", 1'b0, 4'h0, 32'h0, 32'd0, 32'h0BADF00D, 1'b0);
    txn2("rd1000", 1'b0, 4'h0, 32'h1000, 32'd0, 32'd0, 1'b1);
`else
    txn2("wr1000", 1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, 32'd0, 1'b0);
    txn2("rd0_wrap", 1'b0, 4'h0, 32'h0, 32'd0, 32'h5A5A5A5A, 1'b0);
`endif

    // rdata holds after the response.
    @(negedge clk);
    check("hold_rvalid", {31'd0, rvalid}, 32'd0);
`ifdef RISCV_BUS_SLAVE_ERR_EN
    check("hold_rdata", rdata, 32'd0);
`else
    check("hold_rdata", rdata, 32'h5A5A5A5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_bus_slave_mem.md
Name: riscv_bus_slave_mem

Overview:
- Responder (slave) end of the core's req/gnt/rvalid memory bus: the counterpart to the instruction-fetch and load/store masters.
- Word-organised RAM with a configurable number of wait states, byte-enable writes and strictly one outstanding transaction.
- Instantiated twice in the SoC/test top, once behind each bus master (instruction, data), so pipeline stalls from bus latency can be exercised.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on the bus.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two and at least 2.
- WAIT_CYCLES, 2, extra cycles between grant and response; legal range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-high. Despite the _n suffix, asserting it high resets the block on the next clk edge.
- req  in  1  master request valid.
- gnt  out  1  request accepted this cycle when req && gnt.
- we  in  1  1 = write, 0 = read; sampled at acceptance.
- be  in  4  byte enables for writes; ignored for reads.
- addr  in  ADDR_WIDTH  byte address; addr[1:0] ignored.
- wdata  in  32  write data; sampled at acceptance.
- rvalid  out  1  one-cycle response strobe.
- rdata  out  32  read data, valid while rvalid is high.

Behaviour:
- Reset (rst_n high at an edge):
  - State goes to IDLE; rvalid=0, rdata=0 (and err=0 when the optional feature is built).
  - RAM contents are not cleared.
  - Reset dominates any in-flight transaction: it is dropped and no rvalid is produced for it.
- FSM states: IDLE, WAIT, RESP.
  - gnt is combinational, gnt = (state==IDLE). It does not depend on req.
- IDLE:
  - On req=1, the request is accepted. Latch we/be/addr/wdata and load cnt=WAIT_CYCLES.
  - Next state is RESP if WAIT_CYCLES==0, else WAIT.
  - On req=0, stay in IDLE.
- WAIT:
  - cnt decrements each cycle. When cnt==1, next state is RESP.
  - gnt=0; req is ignored.
- RESP:
  - rvalid=1 for exactly this one cycle; next state is IDLE.
  - A request presented in the cycle after RESP is accepted in that cycle.
- Memory access happens on the edge that enters RESP.
  - Source of the access: the live bus inputs when WAIT_CYCLES==0, otherwise the latched request.
  - Read: rdata <= mem[idx].
  - Write: mem[idx] byte lane k is updated only where be[k]=1; rdata <= 32'h0.
- Word index: idx = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Timing:
  - Acceptance in cycle N gives rvalid in cycle N+1+WAIT_CYCLES.
  - Peak throughput is one transaction per WAIT_CYCLES+2 cycles.
- Ordering: with a single outstanding transaction, a read after a write to the same word returns the written data.
- rdata holds its last value while rvalid=0; masters must not sample it then.
- be=4'b0000 write: no RAM change; rvalid is still produced.
- A master must keep req and its inputs stable until gnt. The block does not check changes made before acceptance.

Optional Feature:
- Macro: RISCV_BUS_SLAVE_ERR_EN.
- With the macro defined:
  - Adds output port err (1 bit), registered, reset 0, meaningful only while rvalid=1.
  - A request is out of range when any addr bit above log2(DEPTH_WORDS)+1 is nonzero. For it:
    - err=1 during its RESP cycle;
    - writes are suppressed (no RAM change);
    - reads return rdata=32'h0.
  - In-range requests give err=0.
- Without the macro: no err port; out-of-range addresses wrap as described in Behaviour.

Test Plan:
1. Reset: drive rst_n high for 2 cycles with req=1. Expect gnt=1 in IDLE but no acceptance while reset is high, rvalid=0, rdata=0. Release reset and expect the first grant on the next cycle with req=1.
2. WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, be=4'hF, accepted in cycle 5; expect rvalid only in cycle 8, rdata=0, gnt=0 in cycles 6–8. Then read 0x10 and expect rdata=0xDEADBEEF with the same 3-cycle latency.
3. Byte enables: with word 0x10=0xDEADBEEF, write wdata 0x11223344 with be=4'b0101. A read must return 0xDE22BE44.
4. WAIT_CYCLES=0, back-to-back: req held high for reads to 0x0, 0x4, 0x8. Expect grants every 2 cycles, rvalid in each following cycle, and data in order.
5. Reset mid-WAIT: accept a write to 0x20, then assert rst_n in the WAIT state. Expect no rvalid for it, state IDLE and gnt=1 after reset; a later read of 0x20 returns the pre-write contents.
6. DEPTH_WORDS=1024: write 0x5A5A5A5A to addr 0x1000, then read addr 0x0.
   - Without RISCV_BUS_SLAVE_ERR_EN: the read returns 0x5A5A5A5A (wrap).
   - With RISCV_BUS_SLAVE_ERR_EN: the write gives err=1, the read of 0x0 is unchanged, and err=0 on that read.
